serial_adder_ctrl: RTL and testbench

Sequential controller that adds two WIDTH-bit operands by driving one shared 2-bit ripple slice over WIDTH/2 clock cycles. The slice is two `fullA` cells chained LSB to MSB. The block keeps the inter-slice carry in a register, shifts operands through the slice, and reports the result with a busy/done handshake. It is the multi-cycle counterpart to the combinational 2-bit adder and is the standard way to reuse that datapath for wider words.

---
 rtl/serial_adder_ctrl_if.sv | 29 ++
 rtl/serial_adder_ctrl.sv | 140 ++++++++++++++
 tb/tb_serial_adder_ctrl.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_adder_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : serial_adder_ctrl_if
// Brief    : Request/result bundle for the serial adder controller.
// Revision : 1.0 - initial release
// ============================================================================
interface serial_adder_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             cin;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, cin, a, b,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, cin, a, b,
    output busy, done, sum, cout
  );
endinterface
`default_nettype wire

// File: rtl/serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : serial_adder_ctrl
// Brief    : Adds two WIDTH-bit words by reusing one 2-bit ripple slice
//            over WIDTH/2 cycles, with a busy/done handshake.
// Revision : 1.0 - initial release
// ============================================================================

module fullA (
  input  wire logic i_a,
  input  wire logic i_b,
  input  wire logic i_ci,
  output logic      o_s,
  output logic      o_co
);
  assign o_s  = i_a ^ i_b ^ i_ci;
  assign o_co = (i_a & i_b) | (i_ci & (i_a ^ i_b));
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  wire logic          clk,
  input  wire logic          rst,
  serial_adder_ctrl_if.slave bus
);
  localparam int c_SLICES = WIDTH / 2;
  localparam int c_IDX_W  = (c_SLICES > 1) ? $clog2(c_SLICES) : 1;
  localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(c_SLICES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  logic [WIDTH-1:0]   r_a_sh;
  logic [WIDTH-1:0]   r_b_sh;
  logic [WIDTH-1:0]   r_acc;
  logic               r_cy;
  logic [c_IDX_W-1:0] r_idx;
  logic               r_busy;
  logic               r_done;
  logic [WIDTH-1:0]   r_sum;
  logic               r_cout;

  logic [2:0]         w_c;
  logic [1:0]         w_slice_sum;
  logic               w_carry;
  logic [WIDTH-1:0]   w_acc_next;
  logic               w_unused_acc;

  // Shared 2-bit ripple slice fed from the operand LSBs and the stored carry
  assign w_c[0] = r_cy;
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_slice
      fullA u_fa (
        .i_a  (r_a_sh[gi]),
        .i_b  (r_b_sh[gi]),
        .i_ci (w_c[gi]),
        .o_s  (w_slice_sum[gi]),
        .o_co (w_c[gi+1])
      );
    end
  endgenerate
  assign w_carry = w_c[2];

  // New slice bits enter at the top so slice i ends up at [2i+1:2i]
  generate
    if (WIDTH == 2) begin : g_acc_narrow
      assign w_acc_next = w_slice_sum;
    end else begin : g_acc_wide
      assign w_acc_next = {w_slice_sum, r_acc[WIDTH-1:2]};
    end
  endgenerate

  // Low accumulator bits are shifted out and never observed
  assign w_unused_acc = ^r_acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_a_sh  <= '0;
      r_b_sh  <= '0;
      r_acc   <= '0;
      r_cy    <= 1'b0;
      r_idx   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_a_sh  <= bus.a;
            r_b_sh  <= bus.b;
            r_cy    <= bus.cin;
            r_acc   <= '0;
            r_idx   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_a_sh <= r_a_sh >> 2;
          r_b_sh <= r_b_sh >> 2;
          r_acc  <= w_acc_next;
          r_cy   <= w_carry;
          r_idx  <= r_idx + 1'b1;
          if (r_idx == c_LAST_IDX) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_sum   <= w_acc_next;
            r_cout  <= w_carry;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.sum  = r_sum;
  assign bus.cout = r_cout;

endmodule
`default_nettype wire

// File: tb/tb_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_adder_ctrl
// Brief    : Directed-vector bench for serial_adder_ctrl at WIDTH=8 and WIDTH=2.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_adder_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  serial_adder_ctrl_if #(.WIDTH(8)) bus8 ();
  serial_adder_ctrl_if #(.WIDTH(2)) bus2 ();

  serial_adder_ctrl #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8.slave));
  serial_adder_ctrl #(.WIDTH(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));

  int n_checks  = 0;
  int n_errors  = 0;
  int done_cnt8 = 0;

  // done level seen at each rising edge; one increment per pulse
  always @(posedge clk) if (bus8.done === 1'b1) done_cnt8 <= done_cnt8 + 1;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       cout;
  } vec8_t;

  typedef struct {
    logic [1:0] a;
    logic [1:0] b;
    logic       cin;
    logic [1:0] sum;
    logic       cout;
  } vec2_t;

  vec8_t      vecs8[10];
  vec2_t      vecs2[4];
  logic [7:0] ba[18];
  logic [7:0] bb[18];
  logic       bc[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one request at the current falling edge and wait for done
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic ci,
                     output logic [7:0] s, output logic co,
                     output int busy_n, output int lat);
    bus8.a     = a;
    bus8.b     = b;
    bus8.cin   = ci;
    bus8.start = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0;
    busy_n = 0;
    lat    = 0;
    while (bus8.done !== 1'b1 && lat < 20) begin
      if (bus8.busy === 1'b1) busy_n++;
      @(negedge clk);
      lat++;
    end
    s  = bus8.sum;
    co = bus8.cout;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] s;
    logic       co;
    int         busy_n;
    int         lat;
    int         cnt0;
    logic [8:0] exp9;

    vecs8[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0};
    vecs8[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs8[2] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1};
    vecs8[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs8[4] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs8[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    vecs8[6] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0};
    vecs8[7] = '{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0};
    vecs8[8] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};
    vecs8[9] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};

    vecs2[0] = '{2'b11, 2'b11, 1'b1, 2'b11, 1'b1};
    vecs2[1] = '{2'b01, 2'b10, 1'b0, 2'b11, 1'b0};
    vecs2[2] = '{2'b10, 2'b10, 1'b0, 2'b00, 1'b1};
    vecs2[3] = '{2'b01, 2'b01, 1'b1, 2'b11, 1'b0};

    for (int c = 0; c < 18; c++) begin
      ba[c] = 8'(c * 37 + 5);
      bb[c] = 8'(c * 91 + 200);
      bc[c] = c[0];
    end

    rst        = 1'b1;
    bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.cin = 1'b0;
    bus2.start = 1'b0; bus2.a = '0; bus2.b = '0; bus2.cin = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_busy", bus8.busy, 0);
    chk("reset_done", bus8.done, 0);
    chk("reset_sum",  bus8.sum,  0);
    chk("reset_cout", bus8.cout, 0);
    chk("reset_w2_sum", bus2.sum, 0);
    rst = 1'b0;
    @(negedge clk);

    // Directed table
    cnt0 = done_cnt8;
    for (int i = 0; i < 10; i++) begin
      op8(vecs8[i].a, vecs8[i].b, vecs8[i].cin, s, co, busy_n, lat);
      chk($sformatf("vec%0d_sum", i),  s,  vecs8[i].sum);
      chk($sformatf("vec%0d_cout", i), co, vecs8[i].cout);
      chk($sformatf("vec%0d_busy_cycles", i), busy_n, 4);
      chk($sformatf("vec%0d_latency", i), lat, 4);
      chk($sformatf("vec%0d_busy_at_done", i), bus8.busy, 0);
      @(negedge clk);
      chk($sformatf("vec%0d_done_pulse", i), bus8.done, 0);
      repeat (2) @(negedge clk);
      chk($sformatf("vec%0d_sum_hold", i), bus8.sum, vecs8[i].sum);
    end
    chk("vec_done_count", done_cnt8 - cnt0, 10);

    // Random operands against a + b + cin
    cnt0 = done_cnt8;
    for (int i = 0; i < 1000; i++) begin
      logic [7:0] ra, rb;
      logic       rc;
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      exp9 = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
      op8(ra, rb, rc, s, co, busy_n, lat);
      chk("rand_result", {co, s}, exp9);
      chk("rand_latency", lat, 4);
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
    chk("rand_done_count", done_cnt8 - cnt0, 1000);

    // Start ignored while busy
    cnt0 = done_cnt8;
    bus8.a = 8'h10; bus8.b = 8'h20; bus8.cin = 1'b0; bus8.start = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0;
    @(negedge clk);
    bus8.a = 8'hFF; bus8.b = 8'hFF; bus8.start = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0; bus8.a = 8'h00; bus8.b = 8'h00;
    lat = 0;
    while (bus8.done !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("busy_ignore_sum",  bus8.sum,  8'h30);
    chk("busy_ignore_cout", bus8.cout, 0);
    repeat (10) @(negedge clk);
    chk("busy_ignore_single_done", done_cnt8 - cnt0, 1);

    // Reset in the second RUN cycle
    cnt0 = done_cnt8;
    bus8.a = 8'hAA; bus8.b = 8'h55; bus8.cin = 1'b0; bus8.start = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", bus8.busy, 0);
    chk("midrst_done", bus8.done, 0);
    chk("midrst_sum",  bus8.sum,  0);
    chk("midrst_cout", bus8.cout, 0);
    repeat (8) @(negedge clk);
    chk("midrst_no_done", done_cnt8 - cnt0, 0);
    op8(8'h01, 8'h01, 1'b0, s, co, busy_n, lat);
    chk("midrst_fresh_sum",  s,  8'h02);
    chk("midrst_fresh_cout", co, 0);
    repeat (2) @(negedge clk);

    // Reset and start together: reset wins
    cnt0 = done_cnt8;
    rst = 1'b1; bus8.a = 8'h03; bus8.b = 8'h04; bus8.start = 1'b1;
    @(negedge clk);
    rst = 1'b0; bus8.start = 1'b0;
    chk("rst_start_busy", bus8.busy, 0);
    repeat (6) @(negedge clk);
    chk("rst_start_no_done", done_cnt8 - cnt0, 0);
    chk("rst_start_sum", bus8.sum, 0);

    // Back-to-back with start held high and operands changing every cycle
    cnt0 = done_cnt8;
    bus8.start = 1'b1;
    for (int c = 0; c < 18; c++) begin
      bus8.a   = ba[c];
      bus8.b   = bb[c];
      bus8.cin = bc[c];
      @(negedge clk);
      chk($sformatf("b2b_done_c%0d", c), bus8.done, (c % 6 == 4) ? 1 : 0);
      if (c % 6 == 4) begin
        exp9 = {1'b0, ba[c-4]} + {1'b0, bb[c-4]} + {8'd0, bc[c-4]};
        chk($sformatf("b2b_result_c%0d", c), {bus8.cout, bus8.sum}, exp9);
      end
    end
    bus8.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("b2b_done_count", done_cnt8 - cnt0, 3);

    // WIDTH=2 instance: single RUN cycle
    for (int i = 0; i < 4; i++) begin
      bus2.a = vecs2[i].a; bus2.b = vecs2[i].b; bus2.cin = vecs2[i].cin;
      bus2.start = 1'b1;
      @(negedge clk);
      bus2.start = 1'b0;
      chk($sformatf("w2_%0d_busy", i), bus2.busy, 1);
      chk($sformatf("w2_%0d_early_done", i), bus2.done, 0);
      @(negedge clk);
      chk($sformatf("w2_%0d_done", i), bus2.done, 1);
      chk($sformatf("w2_%0d_busy_at_done", i), bus2.busy, 0);
      chk($sformatf("w2_%0d_sum", i),  bus2.sum,  vecs2[i].sum);
      chk($sformatf("w2_%0d_cout", i), bus2.cout, vecs2[i].cout);
      @(negedge clk);
      chk($sformatf("w2_%0d_done_pulse", i), bus2.done, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
